// File: rtl/apb_master_bridge.sv
// Single-outstanding host-to-APB bridge: decodes a slave window, runs SETUP/ACCESS,
// and returns the slave response, a decode error or a wait-state timeout.
module apb_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int SLV_AW  = 12,
  parameter int IDX_W   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                        PCLK,
  input  logic                        PRESET,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic [DATA_W-1:0]           req_wdata,
  input  logic [DATA_W/8-1:0]         req_strb,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        rsp_err,
  output logic [ADDR_W-1:0]           PADDR,
  output logic [NUM_SLV-1:0]          PSEL,
  output logic                        PENABLE,
  output logic                        PWRITE,
  output logic [DATA_W-1:0]           PWDATA,
  output logic [DATA_W/8-1:0]         PSTRB,
  input  logic [NUM_SLV*DATA_W-1:0]   PRDATA,
  input  logic [NUM_SLV-1:0]          PREADY,
  input  logic [NUM_SLV-1:0]          PSLVERR,
  output logic [1:0]                  dbg_state_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [IDX_W:0]   SLV_LIM  = (IDX_W + 1)'(NUM_SLV);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [STRB_W-1:0] pstrb_q, pstrb_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [IDX_W-1:0]  req_idx;
  logic              req_mapped;
  logic [DATA_W-1:0] sel_rdata;
  logic              sel_ready;
  logic              sel_err;
  logic              sel_active;

  assign req_idx    = req_addr[SLV_AW +: IDX_W];
  assign req_mapped = ({1'b0, req_idx} < SLV_LIM);
  assign sel_active = (state_q == ST_SETUP) || (state_q == ST_ACCESS);

  // Route the addressed slave's return signals; idx_q is always mapped while selected.
  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    PSEL      = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (idx_q == IDX_W'(k)) begin
        sel_rdata = PRDATA[k*DATA_W +: DATA_W];
        sel_ready = PREADY[k];
        sel_err   = PSLVERR[k];
        PSEL[k]   = sel_active;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          idx_d    = req_idx;
          paddr_d  = req_addr;
          pwrite_d = req_write;
          pwdata_d = req_wdata;
          pstrb_d  = req_write ? req_strb : '0;
          cnt_d    = '0;
          if (req_mapped) begin
            state_d = ST_SETUP;
          end else begin
            state_d = ST_RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        // A ready slave on the final wait cycle takes priority over the timeout.
        if (sel_ready) begin
          state_d = ST_RESP;
          err_d   = sel_err;
          rdata_d = pwrite_q ? '0 : sel_rdata;
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = (state_q == ST_RESP);
  assign PENABLE     = (state_q == ST_ACCESS);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign PADDR       = paddr_q;
  assign PWRITE      = pwrite_q;
  assign PWDATA      = pwdata_q;
  assign PSTRB       = pstrb_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Parametrised APB master bridge that converts a single-outstanding valid/ready host request into APB SETUP/ACCESS transfers toward NUM_SLV slaves. Address decode selects one PSEL line from a fixed-size window per slave. Unmapped addresses and stalled slaves (wait-state timeout) return an error response. It is the next-generation replacement for the fixed four-slave APB bridge: width, slave count and window size are configurable, and it adds PSTRB, host backpressure and a timeout.

## Interface
- ADDR_W, 32, host/APB address width
- DATA_W, 32, data width (multiple of 8)
- NUM_SLV, 4, number of APB slaves (1..2^IDX_W)
- SLV_AW, 12, log2 of the byte window per slave
- IDX_W, 4, width of the slave index field; ADDR_W ≥ SLV_AW+IDX_W
- TIMEOUT, 16, maximum wait cycles in ACCESS; 0 disables the timeout
- PCLK  in  1  clock, rising edge
- PRESET  in  1  asynchronous, active-high reset
- req_valid  in  1  host request valid
- req_ready  out  1  bridge can accept a request
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  write data
- req_strb  in  DATA_W/8  write byte strobes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  host accepts response
- rsp_rdata  out  DATA_W  read data (0 for writes and errors)
- rsp_err  out  1  slave error, decode error or timeout
- PADDR  out  ADDR_W  APB address
- PSEL  out  NUM_SLV  one-hot slave select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PWDATA  out  DATA_W  APB write data
- PSTRB  out  DATA_W/8  APB strobes
- PRDATA  in  NUM_SLV*DATA_W  flattened slave read data; slave k occupies bits [k*DATA_W +: DATA_W]
- PREADY  in  NUM_SLV  per-slave ready
- PSLVERR  in  NUM_SLV  per-slave error

## Operation
- Slave index idx = req_addr[SLV_AW +: IDX_W]. Bits above that field are ignored. idx ≥ NUM_SLV means unmapped.
- FSM states:
  - IDLE: req_ready=1 (combinational from state). On req_valid the bridge captures write, addr, wdata, strb and idx.
    - Mapped address: go to SETUP.
    - Unmapped address: go to RESP with rsp_err=1 and rsp_rdata=0. No PSEL is asserted.
  - SETUP: PSEL[idx]=1, PENABLE=0. Always exactly one cycle, then ACCESS.
  - ACCESS: PSEL[idx]=1, PENABLE=1.
    - PREADY[idx]=1: rsp_err=PSLVERR[idx]; rsp_rdata=PRDATA slice idx on a read, 0 on a write; go to RESP.
    - PREADY low: the wait counter increments. When the count reaches TIMEOUT (TIMEOUT>0), the transfer is aborted: PSEL and PENABLE drop, rsp_err=1, rsp_rdata=0, go to RESP.
  - RESP: rsp_valid=1, data held stable. On rsp_ready, go to IDLE.
- PADDR, PWRITE, PWDATA and PSTRB are registered at request capture and held from SETUP through ACCESS. After the transfer they keep their last value.
- PSTRB is forced to 0 on reads.
- Wait counter: width clog2(TIMEOUT+1). Cleared on entry to SETUP. Saturates and never wraps.
- Only one request is outstanding; req_ready=0 outside IDLE.

## Timing
- Reset values: state IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0. req_ready=1 while in reset.
- Request accepted at edge 0. SETUP occupies cycle 1 and ACCESS cycle 2.
  - Zero-wait slave: rsp_valid is high from cycle 3.
  - Each wait state adds one cycle.
  - Unmapped address: rsp_valid is high from cycle 1.
- Timeout: with PREADY held low, the abort occurs after TIMEOUT ACCESS cycles. rsp_valid rises at cycle 2+TIMEOUT, and PSEL is low that same cycle.
- PREADY high on the same cycle the counter reaches TIMEOUT: the slave response wins; there is no timeout error.
- rsp_valid and rsp_ready together in RESP: return to IDLE, with req_ready high next cycle. Throughput for a zero-wait slave with rsp_ready tied high is one transfer per 4 cycles.
- PRESET asserted mid-transfer: all outputs drop to reset values asynchronously. The response is discarded and the slave sees PSEL fall.

## Test plan
- NUM_SLV=4, SLV_AW=12: write 0xDEADBEEF, strb 0xF, to 0x2010; zero-wait slave. Expected: PSEL=0100 and PADDR=0x2010 in cycle 1, PENABLE=1 in cycle 2, rsp_valid in cycle 3 with rsp_err=0 and rsp_rdata=0.
- Read 0x1004; slave 1 holds PREADY low 3 cycles, then returns PRDATA=0x12345678. Expected: ACCESS lasts 4 cycles, PSTRB=0, rsp_rdata=0x12345678, rsp_valid in cycle 6.
- Read 0x5000 (idx 5 ≥ 4). Expected: no PSEL activity, rsp_valid in cycle 1, rsp_err=1, rsp_rdata=0.
- TIMEOUT=16; slave 3 never asserts PREADY. Expected: PSEL drops and rsp_err=1 with rsp_valid at cycle 18. TIMEOUT=0: the bridge waits indefinitely.
- Slave returns PSLVERR=1 with PREADY. Expected: rsp_err=1. Host holds rsp_ready low 5 cycles: rsp_valid and rsp_data stay stable and req_ready stays 0.
- PRESET pulsed during ACCESS. Expected: PSEL, PENABLE and rsp_valid go to 0 immediately and req_ready=1; a subsequent write completes normally.
